// File: rtl/clk_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl_if
// Configuration handshake between the system configuration logic (master)
// and the clock-divider controller (slave).
//   cfg_valid : master offers a new half-period ratio
//   cfg_div   : requested half-period in clk_in cycles (0 is treated as 1)
//   cfg_ready : slave can accept cfg_div this cycle
// Parameter CNT_W must match the CNT_W of the attached clk_div_ctrl.
// ---------------------------------------------------------------------------
interface clk_div_ctrl_if #(
  parameter int CNT_W = 8
) ();
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_div, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
// Programmable clock-divider controller. Produces a registered divided clock
// clk_out (period 2*div_reg clk_in cycles) and a one-cycle tick in the cycle
// clk_out rises. Ratio changes arrive over the cfg handshake and are only
// applied at a period boundary (falling toggle or IDLE entry), and start/stop
// never truncate a clk_out phase.
//
// Ports:
//   clk_in   : sole clock, all state updates on posedge
//   reset    : asynchronous, active-high reset
//   enable   : 1 = run divider, 0 = stop at the next safe point
//   cfg      : configuration handshake (slave side of clk_div_ctrl_if)
//   clk_out  : divided clock
//   tick     : pulse in the cycle clk_out goes 0->1
//   busy     : controller not IDLE
//   edge_cnt : wrapping count of clk_out rising edges
//
// Build option: define CLK_DIV_CNT_EN to implement the edge_cnt counter;
// without it edge_cnt is tied to 0.
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               enable,
  clk_div_ctrl_if.slave      cfg,
  output logic               clk_out,
  output logic               tick,
  output logic               busy,
  output logic [CNT_W-1:0]   edge_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DEF_DIV);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_reg, div_nxt;
  logic [CNT_W-1:0] pend_div, pend_div_nxt;
  logic             pend, pend_nxt;
  logic             clk_nxt, tick_nxt;

  logic             accept;
  logic [CNT_W-1:0] req_div;
  logic             counting, toggle, fall, stop_now;

  assign cfg.cfg_ready = !pend;
  assign busy          = (state != IDLE);

  assign accept  = cfg.cfg_valid && cfg.cfg_ready;
  assign req_div = (cfg.cfg_div == '0) ? ONE : cfg.cfg_div;

  // The counter keeps running in RUN unless we are stopping from a low phase,
  // and always in STOP so the high phase completes in full.
  assign counting = ((state == RUN) && (enable || clk_out)) || (state == STOP);
  // div_reg only changes when cnt returns to 0, so cnt never exceeds div_reg-1.
  assign toggle   = counting && (cnt == div_reg - ONE);
  assign fall     = toggle && clk_out;
  assign stop_now = (state == RUN) && !enable && !clk_out;

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    clk_nxt      = clk_out;
    tick_nxt     = 1'b0;
    div_nxt      = div_reg;
    pend_nxt     = pend;
    pend_div_nxt = pend_div;

    if (counting) begin
      cnt_nxt  = toggle ? '0 : cnt + ONE;
      clk_nxt  = toggle ? !clk_out : clk_out;
      tick_nxt = toggle && !clk_out;
    end

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        clk_nxt = 1'b0;
        if (accept) div_nxt = req_div;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (stop_now) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!enable) begin
          state_nxt = fall ? IDLE : STOP;
        end
      end
      STOP: begin
        if (enable)    state_nxt = RUN;
        else if (fall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Outside IDLE a new ratio waits in pend_div until a period boundary.
    // An offer landing exactly on a boundary is applied directly.
    if (state != IDLE) begin
      if (fall || stop_now) begin
        div_nxt  = accept ? req_div : (pend ? pend_div : div_reg);
        pend_nxt = 1'b0;
      end else if (accept) begin
        pend_nxt     = 1'b1;
        pend_div_nxt = req_div;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      div_reg  <= DIV_INIT;
      pend     <= 1'b0;
      pend_div <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clk_out  <= clk_nxt;
      tick     <= tick_nxt;
      div_reg  <= div_nxt;
      pend     <= pend_nxt;
      pend_div <= pend_div_nxt;
    end
  end

`ifdef CLK_DIV_CNT_EN
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)         edge_cnt <= '0;
    else if (tick_nxt) edge_cnt <= edge_cnt + ONE;
  end
`else
  assign edge_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
// Directed bench for clk_div_ctrl with hand-computed clk_out / tick /
// cfg_ready / busy traces. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;
  localparam int CNT_W = 8;

  logic             clk_in;
  logic             reset;
  logic             enable;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] edge_cnt;

  int errors = 0;
  int checks = 0;

  clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg ();

  clk_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(2)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .enable   (enable),
    .cfg      (cfg.slave),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy),
    .edge_cnt (edge_cnt)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = !clk_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int rises);
`ifdef CLK_DIV_CNT_EN
    return 32'(rises % 256);
`else
    return 32'(rises * 0);
`endif
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Bit i of each vector holds the output sampled after the (i+1)-th edge.
  task automatic run_trace(input int n, output logic [15:0] c, output logic [15:0] t,
                           output logic [15:0] r, output logic [15:0] b);
    c = '0; t = '0; r = '0; b = '0;
    for (int i = 0; i < n; i++) begin
      step();
      c[i] = clk_out;
      t[i] = tick;
      r[i] = cfg.cfg_ready;
      b[i] = busy;
    end
  endtask

  task automatic offer(input logic [CNT_W-1:0] div);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_div   = div;
    step();
    cfg.cfg_valid = 1'b0;
  endtask

  logic [15:0] tc, tt, tr, tb;

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div   = '0;
    step();
    step();
    check("rst_clk_out",   32'(clk_out),       32'd0);
    check("rst_tick",      32'(tick),          32'd0);
    check("rst_cfg_ready", 32'(cfg.cfg_ready), 32'd1);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_edge_cnt",  32'(edge_cnt),      32'd0);

    // Default ratio 2: rise 2 cycles after RUN entry, period 4.
    reset  = 1'b0;
    enable = 1'b1;
    step();
    check("run_entry_busy", 32'(busy), 32'd1);
    run_trace(12, tc, tt, tr, tb);
    check("def_clk_trace",  32'(tc), 32'h0666);
    check("def_tick_trace", 32'(tt), 32'h0222);
    check("def_edge_cnt",   32'(edge_cnt), exp_cnt(3));

    // Ratio change to 5 offered inside a high phase.
    step();
    step();
    check("pre_cfg_high", 32'(clk_out), 32'd1);
    offer(8'd5);
    check("cfg_hold_high",  32'(clk_out),       32'd1);
    check("cfg_ready_low",  32'(cfg.cfg_ready), 32'd0);
    run_trace(11, tc, tt, tr, tb);
    check("div5_clk_trace",   32'(tc), 32'h03E0);
    check("div5_tick_trace",  32'(tt), 32'h0020);
    check("div5_ready_trace", 32'(tr), 32'h07FF);
    check("div5_edge_cnt",    32'(edge_cnt), exp_cnt(5));

    // Glitch-free stop: enable drops one cycle into a 5-cycle high phase.
    for (int i = 0; i < 5; i++) step();
    check("stop_rise_clk",  32'(clk_out), 32'd1);
    check("stop_rise_tick", 32'(tick),    32'd1);
    step();
    enable = 1'b0;
    run_trace(8, tc, tt, tr, tb);
    check("stop_clk_trace",  32'(tc), 32'h0007);
    check("stop_busy_trace", 32'(tb), 32'h0007);
    check("stop_tick_trace", 32'(tt), 32'h0000);

    // Simultaneous cfg accept and enable drop while clk_out is high.
    enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    check("sim_first_rise", 32'(clk_out), 32'd1);
    enable        = 1'b0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_div   = 8'd3;
    step();
    cfg.cfg_valid = 1'b0;
    check("sim_stop_busy",  32'(busy),          32'd1);
    check("sim_stop_ready", 32'(cfg.cfg_ready), 32'd0);
    run_trace(4, tc, tt, tr, tb);
    check("sim_clk_trace",   32'(tc), 32'h0007);
    check("sim_busy_trace",  32'(tb), 32'h0007);
    check("sim_ready_trace", 32'(tr), 32'h0008);
    enable = 1'b1;
    step();
    run_trace(12, tc, tt, tr, tb);
    check("div3_clk_trace",  32'(tc), 32'h071C);
    check("div3_tick_trace", 32'(tt), 32'h0104);
    check("div3_edge_cnt",   32'(edge_cnt), exp_cnt(9));

    // Zero coercion: cfg_div=0 offered in IDLE behaves as 1.
    enable = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);
    offer(8'd0);
    check("idle_ready", 32'(cfg.cfg_ready), 32'd1);
    enable = 1'b1;
    step();
    run_trace(8, tc, tt, tr, tb);
    check("div1_clk_trace",  32'(tc), 32'h0055);
    check("div1_tick_trace", 32'(tt), 32'h0055);

    // Counter wrap: 255 rises, then 256.
    for (int i = 0; i < 484; i++) step();
    check("edge_cnt_255", 32'(edge_cnt), exp_cnt(255));
    step();
    step();
    check("edge_cnt_wrap", 32'(edge_cnt), exp_cnt(256));

    // Async reset in the middle of a 4-cycle high phase.
    enable = 1'b0;
    step();
    offer(8'd4);
    enable = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    check("pre_rst_high", 32'(clk_out), 32'd1);
    step();
    #2 reset = 1'b1;
    #1;
    check("arst_clk_out",   32'(clk_out),       32'd0);
    check("arst_cfg_ready", 32'(cfg.cfg_ready), 32'd1);
    check("arst_busy",      32'(busy),          32'd0);
    check("arst_edge_cnt",  32'(edge_cnt),      32'd0);
    #2 reset = 1'b0;
    step();
    run_trace(4, tc, tt, tr, tb);
    check("arst_div2_trace", 32'(tc), 32'h0006);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Programmable clock-divider controller running on clk_in.
- Generates a divided clock clk_out and a one-cycle tick strobe at each clk_out rising edge.
- Accepts divide-ratio changes over a valid/ready handshake and applies them only at a period boundary, so no clk_out phase is ever truncated.
- Sequences glitch-free start and stop; sits between the system configuration logic and the divided-clock consumers.

Parameters:
- CNT_W, 8, width of the half-period counter, cfg_div and edge_cnt.
- DEF_DIV, 2, half-period in clk_in cycles loaded at reset.

Ports:
- clk_in  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  level; 1 = run divider, 0 = stop at the next safe point.
- cfg_valid  input  1  new ratio offered.
- cfg_div  input  CNT_W  requested half-period in clk_in cycles.
- cfg_ready  output  1  controller can accept cfg_div this cycle.
- clk_out  output  1  divided clock, registered; period = 2*div_reg clk_in cycles.
- tick  output  1  one-cycle pulse in the cycle clk_out goes 0->1.
- busy  output  1  state != IDLE.
- edge_cnt  output  CNT_W  count of clk_out rising edges; wraps.

Behaviour:
Reset (asynchronous, immediate):
- clk_out=0, tick=0, cfg_ready=1, busy=0, edge_cnt=0.
- cnt=0, div_reg=DEF_DIV, pend=0, state=IDLE.
- A reset during a high phase truncates it; this is accepted behaviour.

Handshake and ratio rules:
- Transfer occurs when cfg_valid && cfg_ready.
- cfg_div==0 is coerced to 1.
- cfg_ready = !pend.

States:
- IDLE:
  - clk_out=0, cnt held at 0.
  - An accepted cfg writes div_reg on the next edge, with no pending stage.
  - enable=1 -> RUN. The first clk_out rise occurs div_reg cycles after the RUN entry edge.
- RUN:
  - cnt increments each cycle.
  - At cnt==div_reg-1: cnt<=0 and clk_out toggles.
  - On a 0->1 toggle: tick=1 for that cycle and edge_cnt++ (mod 2^CNT_W).
  - An accepted cfg stores pend_div and sets pend (cfg_ready drops the next cycle).
  - At the next 1->0 toggle: div_reg<=pend_div and pend<=0, so cfg_ready returns 1 the following cycle. The new ratio governs the very next low phase.
  - enable=0 with clk_out=0 -> IDLE on the next edge; cnt clears and a pending ratio is applied.
  - enable=0 with clk_out=1 -> STOP.
- STOP:
  - Counting continues until the 1->0 toggle, then -> IDLE with the pending ratio applied.
  - enable reasserting in STOP -> RUN, with no phase disturbance.

Simultaneous events:
- cfg accept and enable drop in the same cycle: both are honoured; the ratio is applied at the IDLE entry.
- cnt compare uses the old div_reg until the apply edge; cnt never exceeds div_reg-1.
- Ratio changes never occur mid-high-phase.

Optional Feature:
Macro: CLK_DIV_CNT_EN.
- Defined: edge_cnt register and increment logic present as described.
- Not defined: edge_cnt tied to 0, counter logic removed; all other behaviour unchanged.

Test Plan:
- Reset defaults: reset pulse, enable=1 -> clk_out rises 2 cycles after RUN entry, period 4 cycles, tick high once per period; edge_cnt=3 after 3 rises.
- Ratio change: cfg_div=5 accepted mid-high phase -> cfg_ready=0 until the falling toggle; old half-period 2 completes, then 5-cycle low and 5-cycle high phases; cfg_ready=1 one cycle after apply.
- Zero coercion: cfg_div=0 in IDLE, enable=1 -> clk_out period 2 cycles (toggles every cycle).
- Glitch-free stop: enable drops 1 cycle into a 5-cycle high phase -> high phase lasts the full 5 cycles, then clk_out=0, busy=0; no further ticks.
- Simultaneous events: cfg_div=3 accepted in the same cycle enable drops while clk_out=1 -> STOP, then IDLE with div_reg=3; re-enable gives period 6.
- Wrap and async reset: run 256 rises -> edge_cnt wraps to 0 (macro defined; tied 0 otherwise); assert reset mid-high phase -> clk_out=0 immediately, cfg_ready=1, div_reg=2.
